// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Constants and types shared by the PRBS7 (x^7 + x^6 + 1) generator and checker.
//   PRBS_LEN      : LFSR length in bits
//   TAP_A / TAP_B : state bits XORed to predict the next sequence bit
//   SEED_LEN      : number of received bits loaded before prediction is trusted
//   prbs_state_e  : checker state encoding (SEED, HUNT, LOCK)
//   prbs_predict  : next-bit prediction from an LFSR state
// -----------------------------------------------------------------------------
package prbs_pkg;

    localparam int PRBS_LEN = 7;
    localparam int TAP_A    = 6;
    localparam int TAP_B    = 5;
    localparam int SEED_LEN = PRBS_LEN;

    typedef enum logic [1:0] {
        SEED = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } prbs_state_e;

    // Bit s[6] is the oldest bit held, s[5] the next oldest: for x^7 + x^6 + 1
    // the next bit is b[n] = b[n-7] ^ b[n-6].
    function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// -----------------------------------------------------------------------------
// prbs7_lfsr
// 7-bit PRBS7 shift register shared by the generator and the checker. Each
// enabled cycle shifts one bit into s[0]: either an external bit (used to
// seed/track a received stream) or the LFSR's own prediction (free-running).
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset, clears the register to 0
//   en_i       : shift enable
//   sel_ext_i  : 1 = shift in ext_i, 0 = shift in the prediction
//   ext_i      : external bit
//   state_o    : current register contents s[6:0]
//   pred_o     : prediction of the next sequence bit, s[6] ^ s[5]
// -----------------------------------------------------------------------------
module prbs7_lfsr
    import prbs_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                sel_ext_i,
    input  logic                ext_i,
    output logic [PRBS_LEN-1:0] state_o,
    output logic                pred_o
);

    logic [PRBS_LEN-1:0] s_q;
    logic [PRBS_LEN-1:0] s_d;
    logic                in_bit;

    assign pred_o  = prbs_predict(s_q);
    assign state_o = s_q;
    assign in_bit  = sel_ext_i ? ext_i : pred_o;

    always_comb begin
        s_d = s_q;
        if (en_i) begin
            s_d = {s_q[PRBS_LEN-2:0], in_bit};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Serial PRBS7 (x^7 + x^6 + 1) receive checker. Seeds a local LFSR from the
// incoming stream, hunts for LOCK_CNT consecutive correctly predicted bits,
// then free-runs the local sequence and counts bit errors against it.
//
// Optional feature (macro PRBS_CHECKER_RELOCK_EN): while locked, errors are
// counted in windows of LOSS_WIN valid bits; LOSS_ERRS errors inside one
// window drop lock and restart from SEED. Without the macro, lock is held
// until RST and no window logic exists.
//
// Parameters
//   ERR_W     : error counter width
//   LOCK_CNT  : consecutive HUNT matches required to lock (1..255)
//   LOSS_WIN  : loss-detection window in valid bits (relock build only)
//   LOSS_ERRS : errors per window that force relock (relock build only)
//
// Ports
//   CLK     : clock, rising edge
//   RST     : asynchronous active-high reset
//   EN      : DIN valid this cycle; EN=0 freezes all state
//   DIN     : received serial bit
//   CLR     : synchronous clear of ERR_CNT
//   LOCKED  : registered, checker synchronized
//   ERR     : registered one-cycle pulse per detected bit error
//   ERR_CNT : saturating error count
// -----------------------------------------------------------------------------
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int ERR_W     = 16,
    parameter int LOCK_CNT  = 16,
    parameter int LOSS_WIN  = 64,
    parameter int LOSS_ERRS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIN,
    input  logic             CLR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT
);

    if (LOCK_CNT < 1 || LOCK_CNT > 255 || LOSS_WIN < 1 || LOSS_ERRS < 1) begin : g_bad_params
        $error("prbs_checker: parameter out of range");
    end

    localparam logic [2:0] SEED_LAST   = 3'(SEED_LEN - 1);
    localparam logic [7:0] LOCK_CNT_M1 = 8'(LOCK_CNT - 1);

    prbs_state_e         state_q;
    prbs_state_e         state_d;
    logic [2:0]          seed_cnt_q;
    logic [2:0]          seed_cnt_d;
    logic [7:0]          good_cnt_q;
    logic [7:0]          good_cnt_d;
    logic [ERR_W-1:0]    err_cnt_q;
    logic [ERR_W-1:0]    err_cnt_d;
    logic                err_q;
    logic                locked_q;

    logic [PRBS_LEN-1:0] lfsr_s;
    logic                lfsr_pred;
    logic                lfsr_sel_ext;
    logic                mismatch;
    logic                bit_err;
    logic                loss;

    // Received bits feed the LFSR in SEED/HUNT; in LOCK it runs on its own
    // prediction so corrupted bits cannot disturb the reference sequence.
    prbs7_lfsr u_lfsr (
        .clk_i     (CLK),
        .rst_i     (RST),
        .en_i      (EN),
        .sel_ext_i (lfsr_sel_ext),
        .ext_i     (DIN),
        .state_o   (lfsr_s),
        .pred_o    (lfsr_pred)
    );

    assign mismatch = DIN ^ lfsr_pred;
    assign bit_err  = EN && (state_q == LOCK) && mismatch;

`ifdef PRBS_CHECKER_RELOCK_EN
    localparam int WIN_W  = $clog2(LOSS_WIN + 1);
    localparam int ERRS_W = $clog2(LOSS_ERRS + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOSS_WIN - 1);
    localparam logic [ERRS_W-1:0] ERRS_LIM  = ERRS_W'(LOSS_ERRS);

    logic [WIN_W-1:0]  win_cnt_q;
    logic [WIN_W-1:0]  win_cnt_d;
    logic [ERRS_W-1:0] win_errs_q;
    logic [ERRS_W-1:0] win_errs_d;
    logic [ERRS_W-1:0] win_errs_inc;

    // The error on the current bit is included before testing the limit, so
    // the bit that reaches LOSS_ERRS triggers the loss in the same cycle. An
    // error on the last bit of a window still counts toward that window.
    always_comb begin
        win_cnt_d    = win_cnt_q;
        win_errs_d   = win_errs_q;
        loss         = 1'b0;
        win_errs_inc = win_errs_q + ERRS_W'(bit_err);
        if (state_q != LOCK) begin
            win_cnt_d  = '0;
            win_errs_d = '0;
        end else if (EN) begin
            if (win_errs_inc == ERRS_LIM) begin
                loss       = 1'b1;
                win_cnt_d  = '0;
                win_errs_d = '0;
            end else if (win_cnt_q == WIN_LAST) begin
                win_cnt_d  = '0;
                win_errs_d = '0;
            end else begin
                win_cnt_d  = win_cnt_q + WIN_W'(1);
                win_errs_d = win_errs_inc;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win_cnt_q  <= '0;
            win_errs_q <= '0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            win_errs_q <= win_errs_d;
        end
    end
`else
    assign loss = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        seed_cnt_d   = seed_cnt_q;
        good_cnt_d   = good_cnt_q;
        lfsr_sel_ext = 1'b1;
        case (state_q)
            SEED: begin
                if (EN) begin
                    if (seed_cnt_q == SEED_LAST) begin
                        state_d    = HUNT;
                        seed_cnt_d = '0;
                        good_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'(1);
                    end
                end
            end
            HUNT: begin
                // An all-zero register predicts zeros forever; matches made
                // from it are not evidence of a real PRBS stream.
                if (EN) begin
                    if (!mismatch && (|lfsr_s)) begin
                        if (good_cnt_q == LOCK_CNT_M1) begin
                            state_d    = LOCK;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + 8'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            LOCK: begin
                lfsr_sel_ext = 1'b0;
                if (loss) begin
                    state_d    = SEED;
                    seed_cnt_d = '0;
                end
            end
            default: begin
                state_d = SEED;
            end
        endcase
    end

    // CLR wins over the increment but still keeps an error seen this cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (CLR) begin
            err_cnt_d = ERR_W'(bit_err);
        end else if (bit_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= SEED;
            seed_cnt_q <= '0;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_d;
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= bit_err;
            locked_q   <= (state_d == LOCK);
        end
    end

    assign LOCKED  = locked_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;

endmodule
